bcd_to_bin: RTL and testbench
=============================

BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous and active-low.
REQ-003 SHALL have port: start  input  1  conversion request, sampled each clk edge.
REQ-004 SHALL have port: bcd_in  input  12  three packed BCD digits; [11:8] hundreds, [7:4] tens, [3:0] ones.
REQ-005 SHALL have port: busy  output  1  high while a conversion is in progress.
REQ-006 SHALL have port: done  output  1  one-cycle pulse when bin_out and err are updated.
REQ-007 SHALL have port: bin_out  output  10  unsigned binary result, 0..999.
REQ-008 SHALL have port: err  output  1  invalid-digit flag for the last conversion.

Function
REQ-009 SHALL implement FSM states IDLE, SHIFT and DONE; the reset state is IDLE.
REQ-010 In IDLE with start=1, SHALL capture bcd_in into a 12-bit digit register, clear a 10-bit result register and a 4-bit iteration counter, and go to SHIFT.
REQ-011 Each SHIFT cycle SHALL right-shift the concatenation {digit register, result register} by one bit, then subtract 3 from each 4-bit digit that is >=8 after the shift (reverse double-dabble).
REQ-012 SHALL perform exactly 10 SHIFT cycles, counted 0..9, then go to DONE.
REQ-013 In DONE, SHALL drive bin_out from the result register, assert done for that one cycle, and return to IDLE the next cycle.
REQ-014 Latency SHALL be 12 cycles: if start is sampled at edge N, done is high in the cycle after edge N+11.
REQ-015 busy SHALL be high in SHIFT and DONE and low in IDLE; start is accepted only in IDLE.
REQ-016 start asserted while busy=1 SHALL be ignored, with no queuing or restart.
REQ-017 bin_out and err SHALL hold their values from the last DONE until the next DONE.
REQ-018 start held high continuously SHALL begin a new conversion on the first IDLE cycle after each DONE.
REQ-019 bin_out SHALL equal 100*hundreds + 10*tens + ones for every valid input; the maximum value 999 SHALL fit in 10 bits with no overflow.

Reset
REQ-020 rst_n=0 at a clk edge SHALL force IDLE and clear busy, done, bin_out, err, the counter and all internal registers to 0.
REQ-021 Reset asserted mid-conversion SHALL abort the conversion with no done pulse; the next start after release SHALL begin a fresh conversion.
REQ-022 rst_n SHALL take priority over start in the same cycle.

Configuration
REQ-023 Macro BCD_TO_BIN_DIGIT_CHECK_EN SHALL select digit validation.
REQ-024 With the macro defined, a start in IDLE where any digit of bcd_in is >9 SHALL go directly to DONE on the next edge, with bin_out=0 and err=1 in that DONE cycle (latency 2 cycles).
REQ-025 With the macro defined, a valid input SHALL set err=0 at its DONE.
REQ-026 Without the macro, SHALL have no validation logic; err SHALL be tied to 0 and every input SHALL take the full 12-cycle path, with an unspecified bin_out for invalid digits.

Verification
REQ-027 Reset, then bcd_in=12'h999 and start for 1 cycle -> done after 12 cycles, bin_out=999 (10'h3E7), err=0.
REQ-028 bcd_in=12'h000 -> bin_out=0; bcd_in=12'h255 -> bin_out=255 (10'h0FF); bcd_in=12'h100 -> bin_out=100.
REQ-029 Start 12'h123, then pulse start with 12'h456 three cycles later -> a single done, bin_out=123.
REQ-030 Start 12'h789, assert rst_n=0 at cycle 5 -> no done, all outputs 0; then start 12'h042 -> bin_out=42.
REQ-031 With BCD_TO_BIN_DIGIT_CHECK_EN defined, bcd_in=12'h1A3 -> done 2 cycles after start, err=1, bin_out=0; a following 12'h010 -> err=0, bin_out=10.
REQ-032 Exhaustive sweep of 000..999 with start held high -> each bin_out matches decimal value; done spacing is exactly 12 cycles.

Source files
------------

// File: rtl/bcd_to_bin.sv
// Sequential 3-digit BCD to 10-bit binary converter (reverse double-dabble, 12-cycle latency).
// Optional input digit validation is enabled by defining BCD_TO_BIN_DIGIT_CHECK_EN.
module bcd_to_bin (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] bcd_in,
  output logic        busy,
  output logic        done,
  output logic [9:0]  bin_out,
  output logic        err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]  r_state;
  logic [11:0] r_digits;
  logic [9:0]  r_result;
  logic [3:0]  r_cnt;
  logic        r_done;
  logic [9:0]  r_bin;

  logic [21:0] w_shifted;
  logic [11:0] w_digits_adj;
  logic [3:0]  w_nib;

  // One reverse double-dabble step: shift right, then correct each BCD digit >= 8 by -3.
  always_comb begin
    w_shifted    = {r_digits, r_result} >> 1;
    w_digits_adj = '0;
    w_nib        = '0;
    for (int unsigned d = 0; d < 3; d++) begin
      w_nib = w_shifted[10 + 4*d +: 4];
      w_digits_adj[4*d +: 4] = (w_nib >= 4'd8) ? (w_nib - 4'd3) : w_nib;
    end
  end

`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
  logic r_inv;
  logic r_err;
  logic w_invalid;

  always_comb begin
    w_invalid = (bcd_in[11:8] > 4'd9) || (bcd_in[7:4] > 4'd9) || (bcd_in[3:0] > 4'd9);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_digits <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_bin    <= '0;
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
      r_inv    <= 1'b0;
      r_err    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_result <= '0;
            r_cnt    <= '0;
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
            if (w_invalid) begin
              // Invalid digits bypass the shifter; the cleared result yields bin_out = 0.
              r_digits <= '0;
              r_inv    <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_digits <= bcd_in;
              r_inv    <= 1'b0;
              r_state  <= SHIFT;
            end
`else
            r_digits <= bcd_in;
            r_state  <= SHIFT;
`endif
          end
        end
        SHIFT: begin
          r_digits <= w_digits_adj;
          r_result <= w_shifted[9:0];
          if (r_cnt == 4'd9) begin
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        DONE: begin
          r_done  <= 1'b1;
          r_bin   <= r_result;
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
          r_err   <= r_inv;
`endif
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy    = (r_state == SHIFT) || (r_state == DONE);
  assign done    = r_done;
  assign bin_out = r_bin;
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
  assign err     = r_err;
`else
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: vector table, random vectors vs. decimal model,
// corner sequences (ignored start, mid-conversion reset) and a full 000..999 sweep.
module tb_bcd_to_bin;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] bcd_in;
  logic        busy;
  logic        done;
  logic [9:0]  bin_out;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  bcd_to_bin dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] bcd;
    int          exp_bin;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int ref_bin(input logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  // Pulses start for one edge and returns the number of edges, start edge included, until done.
  task automatic run_conv(input logic [11:0] b, output int lat);
    bcd_in = b;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    lat    = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  vec_t vecs[8];
  int   lat;
  int   ndone;
  int   last_done;
  logic [9:0] held;

  initial begin
    vecs[0] = '{12'h999, 999};
    vecs[1] = '{12'h000, 0};
    vecs[2] = '{12'h255, 255};
    vecs[3] = '{12'h100, 100};
    vecs[4] = '{12'h042, 42};
    vecs[5] = '{12'h010, 10};
    vecs[6] = '{12'h509, 509};
    vecs[7] = '{12'h990, 990};

    rst_n = 1'b0; start = 1'b0; bcd_in = '0;
    tick(); tick();
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_bin", int'(bin_out), 0);
    check("reset_err", int'(err), 0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      run_conv(vecs[i].bcd, lat);
      check($sformatf("vec%0d_lat", i), lat, 12);
      check($sformatf("vec%0d_bin", i), int'(bin_out), vecs[i].exp_bin);
      check($sformatf("vec%0d_err", i), int'(err), 0);
      check($sformatf("vec%0d_busy", i), int'(busy), 0);
    end

    held = bin_out;
    tick(); tick();
    check("hold_done_low", int'(done), 0);
    check("hold_bin", int'(bin_out), int'(held));

    for (int i = 0; i < 25; i++) begin
      logic [11:0] b;
      b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      run_conv(b, lat);
      check($sformatf("rnd%0d_lat", i), lat, 12);
      check($sformatf("rnd%0d_bin", i), int'(bin_out), ref_bin(b));
    end

    // start while busy is ignored
    bcd_in = 12'h123; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    tick(); tick();
    bcd_in = 12'h456; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      if (done) begin
        ndone++;
        check("ignored_start_bin", int'(bin_out), 123);
      end
      tick();
    end
    check("ignored_start_ndone", ndone, 1);

    // reset mid-conversion aborts without a done pulse
    bcd_in = 12'h789; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_bin", int'(bin_out), 0);
    check("abort_err", int'(err), 0);
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) ndone++;
      tick();
    end
    check("abort_no_done", ndone, 0);
    run_conv(12'h042, lat);
    check("after_abort_lat", lat, 12);
    check("after_abort_bin", int'(bin_out), 42);

    // reset wins over start in the same cycle
    rst_n = 1'b0; bcd_in = 12'h555; start = 1'b1;
    tick();
    rst_n = 1'b1; start = 1'b0;
    check("rst_prio_busy", int'(busy), 0);
    tick();
    check("rst_prio_busy2", int'(busy), 0);

`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
    run_conv(12'h1A3, lat);
    check("inv_lat", lat, 2);
    check("inv_err", int'(err), 1);
    check("inv_bin", int'(bin_out), 0);
    run_conv(12'h010, lat);
    check("valid_after_inv_lat", lat, 12);
    check("valid_after_inv_err", int'(err), 0);
    check("valid_after_inv_bin", int'(bin_out), 10);
`else
    run_conv(12'h1A3, lat);
    check("nochk_lat", lat, 12);
    check("nochk_err", int'(err), 0);
`endif

    // exhaustive sweep with start held high
    tick();
    bcd_in = to_bcd(0); start = 1'b1;
    tick();
    last_done = -1;
    for (int v = 0; v < 1000; v++) begin
      lat = 0;
      while (!done && lat < 40) begin
        tick();
        lat++;
      end
      check($sformatf("sweep%0d_bin", v), int'(bin_out), v);
      if (last_done >= 0) check($sformatf("sweep%0d_spacing", v), cyc - last_done, 12);
      last_done = cyc;
      bcd_in = to_bcd((v + 1) % 1000);
      tick();
    end
    start = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
